// File: rtl/lane_pkg.sv
// Shared definitions for the lane score counter and the downstream max finder.
package lane_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Lowest bit of lane 'lane' inside a packed NUM_LANES*width vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lane_sat_counter.sv
// One lane's hit counter: saturates at all-ones, clear wins over increment.
module lane_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lane_score_counter.sv
// Timed scoring round: counts per-lane hits over a fixed window, then waits
// out the max finder's pipeline before flagging the result as valid.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no round yet; waiting for start, hits ignored
// ST_COUNT  | window open; hits counted, window timer running down
// ST_SETTLE | counts frozen; covering the finder's pipeline latency
// ST_DONE   | counts frozen and final; result_valid high, start restarts
module lane_score_counter
    import lane_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int WINDOW_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_LANES-1:0]       hit,
    output logic [NUM_LANES*WIDTH-1:0] lane_values,
    output logic                       busy,
    output logic                       round_done,
    output logic                       result_valid
);

    localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW_CYCLES - 1);
    // With no settle phase the load value is never used; keep it in range.
    localparam logic [SET_W-1:0] SET_LOAD =
        (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;

    state_e           state_q,  state_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             round_done_q, round_done_d;
    logic             clear_cnt;
    logic             count_en;

    // Next-state, timer and counter-control decode.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        settle_d  = settle_q;
        clear_cnt = 1'b0;
        count_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_COUNT;
                    timer_d   = TMR_LOAD;
                    clear_cnt = 1'b1;
                end
            end
            ST_COUNT: begin
                // The terminal-count edge still counts its hits.
                count_en = 1'b1;
                if (timer_q == '0) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = SET_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        round_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, timers and the round_done pulse register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            settle_q     <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            settle_q     <= settle_d;
            round_done_q <= round_done_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_sat_counter #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear_cnt),
            .inc   (count_en & hit[g]),
            .count (lane_values[lane_lsb(g, WIDTH) +: WIDTH])
        );
    end

    assign busy         = (state_q == ST_COUNT) || (state_q == ST_SETTLE);
    assign result_valid = (state_q == ST_DONE);
    assign round_done   = round_done_q;

endmodule

// File: tb/tb_lane_score_counter.sv
// Bench for lane_score_counter: two instances (window 8 / settle 2 and
// window 20 / settle 0) checked every cycle against a round-level model.
module tb_lane_score_counter;

    localparam int WD = 4;
    localparam int WA = 8;
    localparam int SA = 2;
    localparam int WB = 20;
    localparam int SB = 0;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [3:0]  hit_a, hit_b;
    logic [15:0] lv_a, lv_b;
    logic        busy_a, busy_b, rd_a, rd_b, rv_a, rv_b;

    lane_score_counter #(.WIDTH(WD), .WINDOW_CYCLES(WA), .SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .hit(hit_a),
        .lane_values(lv_a), .busy(busy_a), .round_done(rd_a), .result_valid(rv_a)
    );

    lane_score_counter #(.WIDTH(WD), .WINDOW_CYCLES(WB), .SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .hit(hit_b),
        .lane_values(lv_b), .busy(busy_b), .round_done(rd_b), .result_valid(rv_b)
    );

    int errors = 0;
    int checks = 0;

    // Model: per instance, whether a round was ever started since reset,
    // how many edges have passed since the start edge, and lane totals.
    int win [2] = '{WA, WB};
    int stl [2] = '{SA, SB};
    bit active [2];
    int k [2];
    int cnt [2][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d, input logic rst, input logic st, input logic [3:0] h);
        if (!rst) begin
            active[d] = 1'b0;
            k[d] = 0;
            for (int i = 0; i < 4; i++) cnt[d][i] = 0;
        end else if (st && (!active[d] || k[d] >= win[d] + stl[d])) begin
            active[d] = 1'b1;
            k[d] = 0;
            for (int i = 0; i < 4; i++) cnt[d][i] = 0;
        end else if (active[d]) begin
            if (k[d] <= win[d] + stl[d]) k[d]++;
            if (k[d] <= win[d]) begin
                for (int i = 0; i < 4; i++)
                    if (h[i] && cnt[d][i] < 15) cnt[d][i]++;
            end
        end
    endtask

    function automatic logic [15:0] m_lanes(input int d);
        logic [15:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = cnt[d][i];
            r[i*4 +: 4] = v[3:0];
        end
        return r;
    endfunction

    task automatic check_dut(input int d);
        logic [15:0] lv;
        logic b, rv, rd;
        string p;
        if (d == 0) begin
            lv = lv_a; b = busy_a; rv = rv_a; rd = rd_a; p = "A";
        end else begin
            lv = lv_b; b = busy_b; rv = rv_b; rd = rd_b; p = "B";
        end
        chk({p, "_lane_values"}, 32'(lv), 32'(m_lanes(d)));
        chk({p, "_busy"}, 32'(b), 32'(active[d] && k[d] < win[d] + stl[d]));
        chk({p, "_result_valid"}, 32'(rv), 32'(active[d] && k[d] >= win[d] + stl[d]));
        chk({p, "_round_done"}, 32'(rd), 32'(active[d] && k[d] == win[d] + stl[d]));
    endtask

    task automatic cyc(input logic rst, input logic sa, input logic [3:0] ha,
                       input logic sb, input logic [3:0] hb);
        reset = rst; start_a = sa; hit_a = ha; start_b = sb; hit_b = hb;
        @(posedge clk);
        model_step(0, rst, sa, ha);
        model_step(1, rst, sb, hb);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    function automatic int lane_max(input logic [15:0] v);
        int m;
        m = 0;
        for (int i = 0; i < 4; i++)
            if (int'(v[i*4 +: 4]) > m) m = int'(v[i*4 +: 4]);
        return m;
    endfunction

    initial begin
        int mx;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; hit_a = '0; hit_b = '0;
        for (int i = 0; i < WD; i++) begin
            active[0] = 0; active[1] = 0; k[0] = 0; k[1] = 0;
            cnt[0][i] = 0; cnt[1][i] = 0;
        end

        // Reset held with start and all hits asserted.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'hF, 1'b1, 4'hF);
        // Idle ignores hits.
        cyc(1'b1, 1'b0, 4'hF, 1'b0, 4'hF);

        // Basic round on A; the hit arriving with start is not counted.
        cyc(1'b1, 1'b1, 4'hF, 1'b0, 4'h0);
        for (int e = 1; e <= WA; e++)
            cyc(1'b1, 1'b0, {e <= 7, 1'b0, e <= 5, e <= 3}, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'hF, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'hF, 1'b0, 4'h0);
        chk("basic_lanes_const", 32'(lv_a), 32'h7053);
        chk("basic_rv_at_10", 32'(rv_a), 32'd1);
        mx = 0;
        for (int i = 0; i < 4; i++) if (cnt[0][i] > mx) mx = cnt[0][i];
        chk("basic_max", 32'(lane_max(lv_a)), 32'(mx));
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Restart from DONE; start pulses inside the round are ignored.
        cyc(1'b1, 1'b1, 4'($urandom), 1'b0, 4'h0);
        for (int e = 1; e <= WA + SA; e++)
            cyc(1'b1, (e == 3) || (e == 9), 4'($urandom), 1'b0, 4'h0);
        chk("ignored_start_rv", 32'(rv_a), 32'd1);

        // Back-to-back: start in the first DONE cycle clears and restarts.
        cyc(1'b1, 1'b1, 4'hF, 1'b0, 4'h0);
        chk("b2b_cleared", 32'(lv_a), 32'd0);
        chk("b2b_busy", 32'(busy_a), 32'd1);
        for (int e = 1; e <= WA + SA; e++)
            cyc(1'b1, 1'b0, 4'($urandom), 1'b0, 4'h0);

        // Saturation and window edges on B (no settle phase).
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h0);
        for (int e = 1; e <= WB + 1; e++)
            cyc(1'b1, 1'b0, 4'h0, 1'b0, {1'b0, e <= WB, e == WB + 1, e == WB});
        chk("sat_lane2", 32'(lv_b[11:8]), 32'd15);
        chk("last_edge_lane0", 32'(lv_b[3:0]), 32'd1);
        chk("after_window_lane1", 32'(lv_b[7:4]), 32'd0);

        // Mid-round reset on A, then a clean full round.
        cyc(1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
        for (int e = 1; e <= 4; e++) cyc(1'b1, 1'b0, 4'hF, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'hF, 1'b0, 4'hF);
        chk("midreset_lanes", 32'(lv_a), 32'd0);
        chk("midreset_busy", 32'(busy_a), 32'd0);
        cyc(1'b1, 1'b1, 4'h0, 1'b1, 4'h0);
        for (int e = 1; e <= WB + 2; e++)
            cyc(1'b1, 1'b0, 4'($urandom), 1'b0, 4'($urandom));

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++)
            cyc(($urandom_range(0, 59) != 0),
                ($urandom_range(0, 7) == 0), 4'($urandom),
                ($urandom_range(0, 7) == 0), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
